// File: rtl/axi4_lite_data_ram.sv
// rtl/axi4_lite_data_ram.sv - AXI4-Lite slave data RAM with byte strobes and programmable read latency
// Optional feature: define AXI_RAM_RANGE_CHECK_EN to answer SLVERR for addresses beyond DEPTH words.
module axi4_lite_data_ram #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_LSB     = 2,
  parameter int READ_LATENCY = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  w_state_e              w_state_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic                  aw_have_q, w_have_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         wstrb_q;

  r_state_e              r_state_q;
  logic                  arready_q, rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [3:0]            rcnt_q;

  logic             aw_hs, w_hs, w_commit, aw_oor, ar_oor;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic             unused_bits;

  assign aw_hs    = S_AXI_AWVALID && awready_q;
  assign w_hs     = S_AXI_WVALID && wready_q;
  assign w_commit = (w_state_q != W_RESP) && aw_have_q && w_have_q;
  assign w_idx    = awaddr_q[ADDR_LSB +: IDX_W];
  assign r_idx    = araddr_q[ADDR_LSB +: IDX_W];

`ifdef AXI_RAM_RANGE_CHECK_EN
  assign aw_oor = |(awaddr_q >> (ADDR_LSB + IDX_W));
  assign ar_oor = |(araddr_q >> (ADDR_LSB + IDX_W));
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, awaddr_q, araddr_q};

  // Write channel: AW and W latch independently; the commit fires on the edge after both are held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE, W_WAIT: begin
          if (w_commit) begin
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= aw_oor ? 2'b10 : 2'b00;
            w_state_q <= W_RESP;
          end else begin
            if (aw_hs) begin
              awaddr_q  <= S_AXI_AWADDR;
              aw_have_q <= 1'b1;
            end
            if (w_hs) begin
              wdata_q  <= S_AXI_WDATA;
              wstrb_q  <= S_AXI_WSTRB;
              w_have_q <= 1'b1;
            end
            awready_q <= !(aw_have_q || aw_hs);
            wready_q  <= !(w_have_q || w_hs);
            w_state_q <= (aw_have_q || aw_hs || w_have_q || w_hs) ? W_WAIT : W_IDLE;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && !aw_oor) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb_q[i]) mem_q[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // R_WAIT's final cycle addresses the array, so even latency 0 answers one cycle after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      araddr_q  <= '0;
      rcnt_q    <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (S_AXI_ARVALID && arready_q) begin
            araddr_q  <= S_AXI_ARADDR;
            arready_q <= 1'b0;
            rcnt_q    <= 4'(READ_LATENCY);
            r_state_q <= R_WAIT;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_WAIT: begin
          if (rcnt_q == 4'd0) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= ar_oor ? '0 : mem_q[r_idx];
            rresp_q   <= ar_oor ? 2'b10 : 2'b00;
            r_state_q <= R_RESP;
          end else begin
            rcnt_q <= rcnt_q - 4'd1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
endmodule

// File: tb/tb_axi4_lite_data_ram.sv
// tb/tb_axi4_lite_data_ram.sv - scoreboard bench for axi4_lite_data_ram
module tb_axi4_lite_data_ram;
  localparam int RL = 3;
`ifdef AXI_RAM_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [2:0]  awprot = 3'b101, arprot = 3'b010;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          rise;
  } exp_t;
  exp_t bq[$];
  exp_t rq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4_lite_data_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .ADDR_LSB(2),
                       .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks rise timing and hold stability.
  initial begin
    logic        bv_p, rv_p, rr_p;
    logic [31:0] rd_p;
    logic [1:0]  rs_p;
    exp_t        e;
    bv_p = 1'b0; rv_p = 1'b0; rr_p = 1'b1; rd_p = '0; rs_p = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bvalid && !bv_p) begin
          if (bq.size() == 0) begin
            tests++; fails++;
            $display("FAIL b_unexpected: BVALID rose with no write pending (cycle %0d)", cyc);
          end else check("b_rise_cycle", 32'(cyc), 32'(bq[0].rise));
        end
        if (bvalid && bready && bq.size() != 0) begin
          e = bq.pop_front();
          check("bresp", 32'(bresp), 32'(e.resp));
        end
        if (rvalid && !rv_p) begin
          if (rq.size() == 0) begin
            tests++; fails++;
            $display("FAIL r_unexpected: RVALID rose with no read pending (cycle %0d)", cyc);
          end else check("r_rise_cycle", 32'(cyc), 32'(rq[0].rise));
        end
        if (rv_p && !rr_p) begin
          check("r_hold_valid", 32'(rvalid), 32'd1);
          check("r_hold_data", rdata, rd_p);
          check("r_hold_resp", 32'(rresp), 32'(rs_p));
          check("r_hold_arready", 32'(arready), 32'd0);
        end
        if (rvalid && rready && rq.size() != 0) begin
          e = rq.pop_front();
          check("rdata", rdata, e.data);
          check("rresp", 32'(rresp), 32'(e.resp));
        end
      end
      bv_p = bvalid; rv_p = rvalid; rr_p = rready; rd_p = rdata; rs_p = rresp;
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input logic [1:0] er);
    int   aw_c, w_c;
    exp_t e;
    aw_c = -1; w_c = -1;
    fork
      begin
        repeat (aw_dly) begin @(posedge clk); #1; end
        awaddr = a; awvalid = 1'b1;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (awready) begin aw_c = cyc + 1; break; end
        end
        @(posedge clk); #1; awvalid = 1'b0;
      end
      begin
        repeat (w_dly) begin @(posedge clk); #1; end
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (wready) begin w_c = cyc + 1; break; end
        end
        @(posedge clk); #1; wvalid = 1'b0;
      end
    join
    if (aw_c < 0 || w_c < 0) begin
      tests++; fails++;
      $display("FAIL wr_handshake_timeout: addr %h aw_cycle %0d w_cycle %0d", a, aw_c, w_c);
    end else begin
      e.data = d; e.resp = er; e.rise = ((aw_c > w_c) ? aw_c : w_c) + 1;
      bq.push_back(e);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    int   ar_c;
    exp_t e;
    ar_c = -1;
    araddr = a; arvalid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (arready) begin ar_c = cyc + 1; break; end
    end
    @(posedge clk); #1; arvalid = 1'b0;
    if (ar_c < 0) begin
      tests++; fails++;
      $display("FAIL rd_handshake_timeout: addr %h", a);
    end else begin
      e.data = ed; e.resp = er; e.rise = ar_c + RL + 1;
      rq.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && (bq.size() != 0 || rq.size() != 0); k++) begin
      @(posedge clk); #1;
    end
    if (bq.size() != 0 || rq.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d writes, %0d reads outstanding", bq.size(), rq.size());
      bq.delete(); rq.delete();
    end
  endtask

  task automatic release_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_first_edge", 32'({awready, wready, arready}), 32'd0);
    @(negedge clk);
    check("ready_after_release", 32'({awready, wready, arready}), 32'b111);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check("reset_readies", 32'({awready, wready, arready}), 32'd0);
    check("reset_valids", 32'({bvalid, rvalid, bresp, rresp}), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    release_reset();

    // Same-cycle AW/W, then readback
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00);
    wait_idle();
    do_read(32'h10, 32'hDEADBEEF, 2'b00);
    wait_idle();

    // W first, AW three cycles later, partial strobe
    do_write(32'h10, 32'h0000_1234, 4'b0011, 3, 0, 2'b00);
    wait_idle();
    do_read(32'h10, 32'hDEAD1234, 2'b00);
    wait_idle();

    // AW first, W later; sparse strobe; low address bits ignored
    do_write(32'h14, 32'h11223344, 4'hF, 0, 0, 2'b00);
    wait_idle();
    do_write(32'h14, 32'hAABBCCDD, 4'b1010, 0, 2, 2'b00);
    wait_idle();
    do_read(32'h17, 32'hAA22CC44, 2'b00);
    wait_idle();

    // RREADY held low: response must hold and ARREADY stay low
    rready = 1'b0;
    do_read(32'h10, 32'hDEAD1234, 2'b00);
    repeat (RL + 6) begin @(posedge clk); #1; end
    rready = 1'b1;
    wait_idle();

    // Write commit and read sample on the same edge: read sees old data
    do_write(32'h20, 32'h77, 4'hF, 0, 0, 2'b00);
    wait_idle();
    fork
      do_read(32'h20, 32'h77, 2'b00);
      do_write(32'h20, 32'h5, 4'hF, RL, RL, 2'b00);
    join
    wait_idle();
    do_read(32'h20, 32'h5, 2'b00);
    wait_idle();

    // Range behaviour depends on AXI_RAM_RANGE_CHECK_EN
    do_write(32'h0, 32'h01020304, 4'hF, 0, 0, 2'b00);
    wait_idle();
    do_write(32'h1000, 32'hA5A5A5A5, 4'hF, 0, 0, RANGE_CHK ? 2'b10 : 2'b00);
    wait_idle();
    do_read(32'h0, RANGE_CHK ? 32'h01020304 : 32'hA5A5A5A5, 2'b00);
    wait_idle();
    do_read(32'h1000, RANGE_CHK ? 32'h0 : 32'hA5A5A5A5, RANGE_CHK ? 2'b10 : 2'b00);
    wait_idle();

    // Reset while BVALID is high and the read is still counting latency
    bready = 1'b0;
    do_write(32'h30, 32'h99, 4'hF, 0, 0, 2'b00);
    do_read(32'h10, 32'hDEAD1234, 2'b00);
    check("pre_reset_bvalid", 32'(bvalid), 32'd1);
    #2; rst_n = 1'b0; #1;
    check("async_reset_valids", 32'({bvalid, rvalid}), 32'd0);
    check("async_reset_readies", 32'({awready, wready, arready}), 32'd0);
    bq.delete(); rq.delete();
    bready = 1'b1;
    release_reset();
    do_read(32'h10, 32'hDEAD1234, 2'b00);
    wait_idle();
    do_read(32'h30, 32'h99, 2'b00);
    wait_idle();
    do_read(32'h20, 32'h5, 2'b00);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
